// File: rtl/tdc_bank_axi_regs.sv
// AXI4-Lite register file for the TDC bank: control, calibration, channel select,
// scratch, status and latched sample, with SLVERR on writes to read-only/reserved slots.
module tdc_bank_axi_regs #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 5,
   parameter int N_TDC              = 8
) (
   input  logic                              s00_axi_aclk,
   input  logic                              s00_axi_reset,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
   input  logic [2:0]                        s00_axi_awprot,
   input  logic                              s00_axi_awvalid,
   output logic                              s00_axi_awready,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
   input  logic                              s00_axi_wvalid,
   output logic                              s00_axi_wready,
   output logic [1:0]                        s00_axi_bresp,
   output logic                              s00_axi_bvalid,
   input  logic                              s00_axi_bready,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
   input  logic [2:0]                        s00_axi_arprot,
   input  logic                              s00_axi_arvalid,
   output logic                              s00_axi_arready,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
   output logic [1:0]                        s00_axi_rresp,
   output logic                              s00_axi_rvalid,
   input  logic                              s00_axi_rready,
   output logic                              tdc_start,
   output logic [31:0]                       tdc_calib,
   output logic [((N_TDC > 1) ? $clog2(N_TDC) : 1)-1:0] tdc_sel,
   input  logic [31:0]                       tdc_data,
   input  logic                              tdc_valid
);

   localparam int SEL_W = (N_TDC > 1) ? $clog2(N_TDC) : 1;

   localparam logic [2:0] SLOT_CTRL   = 3'd0;
   localparam logic [2:0] SLOT_CALIB  = 3'd1;
   localparam logic [2:0] SLOT_SEL    = 3'd2;
   localparam logic [2:0] SLOT_USER   = 3'd3;
   localparam logic [2:0] SLOT_STATUS = 3'd4;
   localparam logic [2:0] SLOT_SAMPLE = 3'd5;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   logic [31:0] ctrl_r, calib_r, sel_r, user_r, sample_r;
   logic        sample_ready_r, overrun_r, tdc_start_r;
   logic        awready_r, wready_r, bvalid_r, arready_r, rvalid_r;
   logic [1:0]  bresp_r, rresp_r;
   logic [31:0] rdata_r;

   logic        wr_accept_s, rd_accept_s, sel_err_s, ovr_clr_s, smp_clr_s;
   logic [2:0]  wr_slot_s, rd_slot_s;
   logic [31:0] status_s, rd_mux_s;
   logic        unused_s;

   // Byte-lane merge: strobed bytes take the new value, others keep the old one.
   function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
      logic [31:0] res;
      res = old_v;
      for (int k = 0; k < 4; k++) begin
         if (strb[k]) begin
            res[8*k +: 8] = new_v[8*k +: 8];
         end
      end
      return res;
   endfunction

   assign wr_slot_s   = s00_axi_awaddr[4:2];
   assign rd_slot_s   = s00_axi_araddr[4:2];
   assign wr_accept_s = awready_r & s00_axi_awvalid & s00_axi_wvalid;
   assign rd_accept_s = arready_r & s00_axi_arvalid;
   assign sel_err_s   = (sel_r >= 32'(N_TDC));
   assign status_s    = {29'd0, sel_err_s, overrun_r, sample_ready_r};
   assign ovr_clr_s   = wr_accept_s & (wr_slot_s == SLOT_CTRL) & s00_axi_wstrb[0] & s00_axi_wdata[1];
   assign smp_clr_s   = rd_accept_s & (rd_slot_s == SLOT_SAMPLE);
   assign unused_s    = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

   // Read data selection; reserved slots return zero.
   always_comb begin
      rd_mux_s = 32'd0;
      case (rd_slot_s)
         SLOT_CTRL:   rd_mux_s = ctrl_r;
         SLOT_CALIB:  rd_mux_s = calib_r;
         SLOT_SEL:    rd_mux_s = sel_r;
         SLOT_USER:   rd_mux_s = user_r;
         SLOT_STATUS: rd_mux_s = status_s;
         SLOT_SAMPLE: rd_mux_s = sample_r;
         default:     rd_mux_s = 32'd0;
      endcase
   end

   // Write channel handshake, register updates and start pulse.
   always_ff @(posedge s00_axi_aclk) begin
      if (s00_axi_reset) begin
         awready_r   <= 1'b0;
         wready_r    <= 1'b0;
         bvalid_r    <= 1'b0;
         bresp_r     <= RESP_OKAY;
         tdc_start_r <= 1'b0;
         ctrl_r      <= 32'd0;
         calib_r     <= 32'd0;
         sel_r       <= 32'd0;
         user_r      <= 32'd0;
      end else begin
         tdc_start_r <= 1'b0;
         if (bvalid_r && s00_axi_bready) begin
            bvalid_r <= 1'b0;
         end
         if (wr_accept_s) begin
            awready_r <= 1'b0;
            wready_r  <= 1'b0;
            bvalid_r  <= 1'b1;
            bresp_r   <= wr_slot_s[2] ? RESP_SLVERR : RESP_OKAY;
            case (wr_slot_s)
               SLOT_CTRL: begin
                  ctrl_r      <= byte_merge(ctrl_r, s00_axi_wdata, s00_axi_wstrb);
                  tdc_start_r <= s00_axi_wstrb[0] & s00_axi_wdata[0];
               end
               SLOT_CALIB: calib_r <= byte_merge(calib_r, s00_axi_wdata, s00_axi_wstrb);
               SLOT_SEL:   sel_r   <= byte_merge(sel_r, s00_axi_wdata, s00_axi_wstrb);
               SLOT_USER:  user_r  <= byte_merge(user_r, s00_axi_wdata, s00_axi_wstrb);
               default: ;
            endcase
         end else if (!awready_r && s00_axi_awvalid && s00_axi_wvalid && !bvalid_r) begin
            awready_r <= 1'b1;
            wready_r  <= 1'b1;
         end
      end
   end

   // Sample capture and status flags; a new sample and overrun set win over clears.
   always_ff @(posedge s00_axi_aclk) begin
      if (s00_axi_reset) begin
         sample_r       <= 32'd0;
         sample_ready_r <= 1'b0;
         overrun_r      <= 1'b0;
      end else begin
         if (tdc_valid) begin
            sample_r       <= tdc_data;
            sample_ready_r <= 1'b1;
         end else if (smp_clr_s) begin
            sample_ready_r <= 1'b0;
         end
         if (tdc_valid && sample_ready_r) begin
            overrun_r <= 1'b1;
         end else if (ovr_clr_s) begin
            overrun_r <= 1'b0;
         end
      end
   end

   // Read channel handshake; data is captured at accept and held until rready.
   always_ff @(posedge s00_axi_aclk) begin
      if (s00_axi_reset) begin
         arready_r <= 1'b0;
         rvalid_r  <= 1'b0;
         rdata_r   <= 32'd0;
         rresp_r   <= RESP_OKAY;
      end else begin
         if (rvalid_r && s00_axi_rready) begin
            rvalid_r <= 1'b0;
         end
         if (rd_accept_s) begin
            arready_r <= 1'b0;
            rvalid_r  <= 1'b1;
            rdata_r   <= rd_mux_s;
            rresp_r   <= RESP_OKAY;
         end else if (!arready_r && s00_axi_arvalid && !rvalid_r) begin
            arready_r <= 1'b1;
         end
      end
   end

   assign s00_axi_awready = awready_r;
   assign s00_axi_wready  = wready_r;
   assign s00_axi_bvalid  = bvalid_r;
   assign s00_axi_bresp   = bresp_r;
   assign s00_axi_arready = arready_r;
   assign s00_axi_rvalid  = rvalid_r;
   assign s00_axi_rdata   = rdata_r;
   assign s00_axi_rresp   = rresp_r;
   assign tdc_start       = tdc_start_r;
   assign tdc_calib       = calib_r;
   assign tdc_sel         = sel_r[SEL_W-1:0];

endmodule

// File: tb/tb_tdc_bank_axi_regs.sv
// Directed bench for tdc_bank_axi_regs: register access, byte strobes, handshake
// ordering, sample/status behaviour, error responses and mid-transaction reset.
module tb_tdc_bank_axi_regs;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  awaddr, araddr;
   logic [2:0]  awprot, arprot;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [31:0] wdata, rdata;
   logic [3:0]  wstrb;
   logic [1:0]  bresp, rresp;
   logic        tdc_start, tdc_valid;
   logic [31:0] tdc_calib, tdc_data;
   logic [2:0]  tdc_sel;

   int n_cmp = 0;
   int n_err = 0;
   int start_cnt = 0;

   tdc_bank_axi_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5), .N_TDC(8)) dut (
      .s00_axi_aclk(clk), .s00_axi_reset(rst),
      .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
      .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
      .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
      .s00_axi_araddr(araddr), .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
      .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
      .tdc_start(tdc_start), .tdc_calib(tdc_calib), .tdc_sel(tdc_sel),
      .tdc_data(tdc_data), .tdc_valid(tdc_valid)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (tdc_start) start_cnt <= start_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits for awready/wready, lets the accept edge pass, then drops the valids.
   task automatic wait_wr_accept(input string tag);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (awready && wready) begin
            ok = 1'b1;
            tick();
            awvalid = 1'b0;
            wvalid  = 1'b0;
            break;
         end
      end
      check({tag, "_accept_timeout"}, {31'd0, ok}, 32'd1);
   endtask

   task automatic wait_bresp(input string tag, output logic [1:0] resp);
      logic ok;
      ok = 1'b0;
      resp = 2'bxx;
      bready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (bvalid) begin
            ok = 1'b1;
            resp = bresp;
            tick();
            break;
         end
         tick();
      end
      bready = 1'b0;
      check({tag, "_b_timeout"}, {31'd0, ok}, 32'd1);
   endtask

   task automatic axi_write(input string tag, input logic [4:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [1:0] exp_resp);
      logic [1:0] r;
      awaddr = a; wdata = d; wstrb = s;
      awvalid = 1'b1; wvalid = 1'b1;
      wait_wr_accept(tag);
      wait_bresp(tag, r);
      check({tag, "_bresp"}, {30'd0, r}, {30'd0, exp_resp});
   endtask

   task automatic axi_read(input string tag, input logic [4:0] a, input logic [31:0] exp);
      logic ok;
      logic [31:0] d;
      logic [1:0]  r;
      ok = 1'b0;
      d = 32'hx; r = 2'bxx;
      araddr = a;
      arvalid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (arready) begin
            tick();
            arvalid = 1'b0;
            break;
         end
      end
      rready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (rvalid) begin
            ok = 1'b1;
            d = rdata;
            r = rresp;
            tick();
            break;
         end
         tick();
      end
      rready = 1'b0;
      arvalid = 1'b0;
      check({tag, "_r_timeout"}, {31'd0, ok}, 32'd1);
      check({tag, "_rdata"}, d, exp);
      check({tag, "_rresp"}, {30'd0, r}, 32'd0);
   endtask

   task automatic pulse_tdc(input logic [31:0] d);
      tdc_data = d;
      tdc_valid = 1'b1;
      tick();
      tdc_valid = 1'b0;
   endtask

   initial begin
      int acc;
      int s0;
      logic [1:0] r;
      rst = 1'b1;
      awaddr = 5'd0; araddr = 5'd0; awprot = 3'd0; arprot = 3'd0;
      awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
      wdata = 32'd0; wstrb = 4'd0; tdc_data = 32'd0; tdc_valid = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      tick();

      check("rst_awready", {31'd0, awready}, 32'd0);
      check("rst_bvalid", {31'd0, bvalid}, 32'd0);
      check("rst_rvalid", {31'd0, rvalid}, 32'd0);
      check("rst_arready", {31'd0, arready}, 32'd0);
      check("rst_start", {31'd0, tdc_start}, 32'd0);
      check("rst_calib", tdc_calib, 32'd0);
      check("rst_resp", {28'd0, bresp, rresp}, 32'd0);

      axi_write("w_ctrl", 5'h00, 32'd1, 4'hF, 2'b00);
      axi_write("w_calib", 5'h04, 32'd2, 4'hF, 2'b00);
      axi_write("w_sel", 5'h08, 32'd3, 4'hF, 2'b00);
      axi_write("w_user", 5'h0C, 32'd4, 4'hF, 2'b00);
      axi_read("r_ctrl", 5'h00, 32'd1);
      axi_read("r_calib", 5'h04, 32'd2);
      axi_read("r_sel", 5'h08, 32'd3);
      axi_read("r_user", 5'h0C, 32'd4);
      check("calib_port", tdc_calib, 32'd2);
      check("sel_port", {29'd0, tdc_sel}, 32'd3);

      axi_write("w_user_full", 5'h0C, 32'h11223344, 4'hF, 2'b00);
      axi_write("w_user_strb", 5'h0E, 32'hAABBCCDD, 4'b0101, 2'b00);
      axi_read("r_user_strb", 5'h0C, 32'h11BB33DD);

      // AW three cycles ahead of W, response held off by bready low.
      awaddr = 5'h0C; wdata = 32'h55; wstrb = 4'hF;
      awvalid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("aw_early_no_ready", {31'd0, awready}, 32'd0);
      end
      wvalid = 1'b1;
      acc = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (awready && wready) begin
            acc++;
            tick();
            awvalid = 1'b0;
            wvalid = 1'b0;
            break;
         end
      end
      check("aw_early_accepts", acc, 32'd1);
      check("aw_early_bvalid", {31'd0, bvalid}, 32'd1);
      awaddr = 5'h0C; wdata = 32'h66; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bhold_bvalid", {31'd0, bvalid}, 32'd1);
         check("bhold_no_accept", {31'd0, awready}, 32'd0);
      end
      bready = 1'b1;
      tick();
      bready = 1'b0;
      check("bhold_released", {31'd0, bvalid}, 32'd0);
      wait_wr_accept("second_wr");
      wait_bresp("second_wr", r);
      check("second_wr_bresp", {30'd0, r}, 32'd0);
      axi_read("r_user_second", 5'h0C, 32'h66);

      pulse_tdc(32'h000000A5);
      axi_read("r_status_rdy", 5'h10, 32'd1);
      axi_read("r_sample", 5'h14, 32'hA5);
      axi_read("r_status_clr", 5'h10, 32'd0);
      pulse_tdc(32'h1);
      pulse_tdc(32'h2);
      axi_read("r_status_ovr", 5'h10, 32'd3);
      axi_write("w_ovr_clr", 5'h00, 32'd2, 4'hF, 2'b00);
      axi_read("r_status_ovr_clr", 5'h10, 32'd1);

      axi_write("w_status", 5'h10, 32'hFFFFFFFF, 4'hF, 2'b10);
      axi_read("r_status_unch", 5'h10, 32'd1);
      axi_write("w_rsvd", 5'h18, 32'h12345678, 4'hF, 2'b10);
      axi_read("r_rsvd", 5'h18, 32'd0);
      axi_write("w_sel8", 5'h08, 32'd8, 4'hF, 2'b00);
      axi_read("r_status_selerr", 5'h10, 32'd5);
      axi_read("r_sel8", 5'h08, 32'd8);
      axi_write("w_sel7", 5'h08, 32'd7, 4'hF, 2'b00);
      axi_read("r_status_selok", 5'h10, 32'd1);
      check("sel_port7", {29'd0, tdc_sel}, 32'd7);

      s0 = start_cnt;
      axi_write("w_start", 5'h00, 32'd1, 4'hF, 2'b00);
      repeat (4) tick();
      check("start_pulses", start_cnt - s0, 32'd1);

      // Reset while a read response is pending.
      araddr = 5'h0C;
      arvalid = 1'b1;
      acc = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (arready) begin
            acc = 1;
            tick();
            arvalid = 1'b0;
            break;
         end
      end
      arvalid = 1'b0;
      check("rst_mid_accept", acc, 32'd1);
      check("rst_mid_rvalid_pre", {31'd0, rvalid}, 32'd1);
      rst = 1'b1;
      tick();
      check("rst_mid_rvalid", {31'd0, rvalid}, 32'd0);
      check("rst_mid_arready", {31'd0, arready}, 32'd0);
      rst = 1'b0;
      tick();
      check("rst_mid_rvalid_after", {31'd0, rvalid}, 32'd0);
      axi_read("post_rst_ctrl", 5'h00, 32'd0);
      axi_read("post_rst_calib", 5'h04, 32'd0);
      axi_read("post_rst_sel", 5'h08, 32'd0);
      axi_read("post_rst_user", 5'h0C, 32'd0);
      axi_read("post_rst_status", 5'h10, 32'd0);
      axi_read("post_rst_sample", 5'h14, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
